// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe board storage, move validation/write and winning-line scan.
// Define BOARD_FAST_SCAN_EN to evaluate all 8 lines in a single SCAN cycle.
module board_ctrl #(
  parameter int POS_W  = 4,
  parameter int CELL_W = 2
) (
  input  logic              clk,
  input  logic              hrd_rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [POS_W-1:0]  req_pos,
  input  logic [CELL_W-1:0] req_player,
  output logic              ack,
  output logic              nack,
  output logic              win,
  output logic [CELL_W-1:0] winner,
  output logic              full,
  input  logic [POS_W-1:0]  rd_pos,
  output logic [CELL_W-1:0] rd_data
);
  typedef enum logic [2:0] {IDLE, CHECK, WRITE, SCAN, RESP_ACK, RESP_NACK} state_t;
  state_t r_state, w_next;
  logic [CELL_W-1:0] r_cell [9];
  logic [POS_W-1:0]  r_pos;
  logic [CELL_W-1:0] r_player, r_winner, w_target;
  logic r_win, r_full, w_accept, w_bad, w_full, w_scan_done, w_any_hit;
  // Three packed 4-bit cell indices per line, scan order rows, columns, diagonals
  function automatic logic [11:0] line_idx(input logic [2:0] l);
    case (l)
      3'd0:    line_idx = {4'd0, 4'd1, 4'd2};
      3'd1:    line_idx = {4'd3, 4'd4, 4'd5};
      3'd2:    line_idx = {4'd6, 4'd7, 4'd8};
      3'd3:    line_idx = {4'd0, 4'd3, 4'd6};
      3'd4:    line_idx = {4'd1, 4'd4, 4'd7};
      3'd5:    line_idx = {4'd2, 4'd5, 4'd8};
      3'd6:    line_idx = {4'd0, 4'd4, 4'd8};
      default: line_idx = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction
  assign w_accept  = r_state == IDLE && req_valid && req_ready;
  assign w_target  = (r_pos > POS_W'(8)) ? '0 : r_cell[r_pos];
  assign w_bad     = r_pos > POS_W'(8) || (r_player != CELL_W'(1) && r_player != CELL_W'(2)) || w_target != '0;
  assign rd_data   = (rd_pos > POS_W'(8)) ? '0 : r_cell[rd_pos];
  assign win       = r_win;
  assign winner    = r_winner;
  assign full      = r_full;
  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < 9; i++) w_full = w_full & (r_cell[i] != '0);
  end
`ifdef BOARD_FAST_SCAN_EN
  logic w_par_hit;
  always_comb begin
    logic [11:0] idx;
    w_par_hit = 1'b0;
    for (int l = 0; l < 8; l++) begin
      idx = line_idx(3'(l));
      w_par_hit = w_par_hit | (r_cell[idx[11:8]] == r_player && r_cell[idx[7:4]] == r_player && r_cell[idx[3:0]] == r_player);
    end
  end
  assign w_scan_done = 1'b1;
  assign w_any_hit   = w_par_hit;
`else
  logic [2:0]  r_line;
  logic        r_hit, w_line_hit;
  logic [11:0] w_idx;
  assign w_idx       = line_idx(r_line);
  assign w_line_hit  = r_cell[w_idx[11:8]] == r_player && r_cell[w_idx[7:4]] == r_player && r_cell[w_idx[3:0]] == r_player;
  assign w_scan_done = r_line == 3'd7;
  assign w_any_hit   = r_hit | w_line_hit;
  always_ff @(posedge clk or negedge hrd_rst_n) begin
    if (!hrd_rst_n) begin
      r_line <= '0;
      r_hit  <= 1'b0;
    end else if (clear || r_state != SCAN) begin
      r_line <= '0;
      r_hit  <= 1'b0;
    end else begin
      r_line <= r_line + 3'd1;
      r_hit  <= r_hit | w_line_hit;
    end
  end
`endif
  always_ff @(posedge clk or negedge hrd_rst_n) begin
    if (!hrd_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end
  always_comb begin
    w_next    = r_state;
    req_ready = r_state == IDLE && !r_win && !r_full;
    ack       = r_state == RESP_ACK;
    nack      = r_state == RESP_NACK;
    case (r_state)
      IDLE:    w_next = w_accept ? CHECK : IDLE;
      CHECK:   w_next = w_bad ? RESP_NACK : WRITE;
      WRITE:   w_next = SCAN;
      SCAN:    w_next = w_scan_done ? RESP_ACK : SCAN;
      default: w_next = IDLE;
    endcase
    if (clear) w_next = IDLE;
  end
  // Flags update on the edge entering RESP_ACK so they are valid alongside ack
  always_ff @(posedge clk or negedge hrd_rst_n) begin
    if (!hrd_rst_n) begin
      for (int i = 0; i < 9; i++) r_cell[i] <= '0;
      r_pos    <= '0;
      r_player <= '0;
      r_win    <= 1'b0;
      r_winner <= '0;
      r_full   <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 9; i++) r_cell[i] <= '0;
      r_win    <= 1'b0;
      r_winner <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pos    <= req_pos;
        r_player <= req_player;
      end
      if (r_state == WRITE)
        for (int i = 0; i < 9; i++) if (r_pos == POS_W'(i)) r_cell[i] <= r_player;
      if (r_state == SCAN && w_scan_done) begin
        r_full <= w_full;
        if (w_any_hit && !r_win) begin
          r_win    <= 1'b1;
          r_winner <= r_player;
        end
      end
    end
  end
endmodule
